// File: rtl/alu_sequencer_if.sv
// Shared ALU control types and the request/response channel bundle of alu_sequencer.
//
// controlpack
//   alu_op_e     ALU operation code driven to the combinational ALU
//   alu_flag_t   {alu_carry, alu_zero} flag pair
//
// alu_sequencer_if (parameter DATA_BUS_WIDTH: operand/result width)
//   req_valid       requester -> sequencer  request valid
//   req_ready       sequencer -> requester  request ready
//   req_op          requester -> sequencer  operation
//   req_operand_a   requester -> sequencer  first operand
//   req_operand_b   requester -> sequencer  second operand
//   req_with_carry  requester -> sequencer  ADC/SBC request
//   rsp_valid       sequencer -> requester  response valid
//   rsp_ready       requester -> sequencer  response ready
//   rsp_result      sequencer -> requester  registered result
//   rsp_flag        sequencer -> requester  flags of this operation
// modport master: control-unit side; modport slave: sequencer side.

package controlpack;

  typedef enum logic [2:0] {
    OpNop = 3'd0,
    OpAdd = 3'd1,
    OpSub = 3'd2,
    OpAnd = 3'd3,
    OpOr  = 3'd4,
    OpXor = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic alu_carry;
    logic alu_zero;
  } alu_flag_t;

endpackage

interface alu_sequencer_if #(
  parameter int unsigned DATA_BUS_WIDTH = 8
);

  logic                          req_valid;
  logic                          req_ready;
  controlpack::alu_op_e          req_op;
  logic [DATA_BUS_WIDTH-1:0]     req_operand_a;
  logic [DATA_BUS_WIDTH-1:0]     req_operand_b;
  logic                          req_with_carry;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_BUS_WIDTH-1:0]     rsp_result;
  controlpack::alu_flag_t        rsp_flag;

  modport master (
    output req_valid,
    output req_op,
    output req_operand_a,
    output req_operand_b,
    output req_with_carry,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_flag
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_operand_a,
    input  req_operand_b,
    input  req_with_carry,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_flag
  );

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator side of the ALU interface. Accepts one request per handshake,
// drives the combinational ALU, samples its result/flags, updates the architectural flag
// register and returns the result on a valid/ready response channel. No pipelining.
//
// Optional feature: define ALU_CARRY_CHAIN_EN to enable ADC/SBC via a second ALU pass
// (CHAIN state). Without it req_with_carry is ignored and CHAIN is unreachable.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of alu_sequencer_if (request/response channels)
//   alu_op     out  operation to the ALU (NOP outside ISSUE/CHAIN)
//   alu_reg1   out  ALU register1 operand
//   alu_reg2   out  ALU register2 operand
//   alu_result in   ALU result
//   alu_flag   in   ALU flags {alu_carry, alu_zero}
//   flag_q     out  architectural flag register

module alu_sequencer
  import controlpack::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_sequencer_if.slave            bus,
  output alu_op_e                   alu_op,
  output logic [DATA_BUS_WIDTH-1:0] alu_reg1,
  output logic [DATA_BUS_WIDTH-1:0] alu_reg2,
  input  logic [DATA_BUS_WIDTH-1:0] alu_result,
  input  alu_flag_t                 alu_flag,
  output alu_flag_t                 flag_q
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StChain,
    StResp
  } state_e;

  state_e                    state_q, state_d;
  alu_op_e                   op_q, op_d;
  logic [DATA_BUS_WIDTH-1:0] a_q, a_d;
  logic [DATA_BUS_WIDTH-1:0] b_q, b_d;
  logic                      chain_q, chain_d;
  logic [DATA_BUS_WIDTH-1:0] res_q, res_d;
  alu_flag_t                 f_q, f_d;
  alu_flag_t                 flag_d;
  alu_flag_t                 chain_flag;
  logic                      chain_req;

  // The chain decision is taken once, at acceptance, against the flag register as it
  // stands then; the request's own first pass cannot influence it.
`ifdef ALU_CARRY_CHAIN_EN
  assign chain_req = bus.req_with_carry & flag_q.alu_carry &
                     ((bus.req_op == OpAdd) | (bus.req_op == OpSub));
`else
  logic unused_with_carry;
  assign unused_with_carry = bus.req_with_carry;
  assign chain_req         = 1'b0;
`endif

  // Carry/borrow of ADC/SBC is set if either pass produced one; zero comes from the
  // final pass only.
  assign chain_flag.alu_carry = f_q.alu_carry | alu_flag.alu_carry;
  assign chain_flag.alu_zero  = alu_flag.alu_zero;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    chain_d = chain_q;
    res_d   = res_q;
    f_d     = f_q;
    flag_d  = flag_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_operand_a;
          b_d     = bus.req_operand_b;
          chain_d = chain_req;
          state_d = StIssue;
        end
      end

      StIssue: begin
        res_d = alu_result;
        // NOP reports clear flags and must not disturb the architectural flags.
        f_d   = (op_q == OpNop) ? '0 : alu_flag;
        if (chain_q) begin
          state_d = StChain;
        end else begin
          state_d = StResp;
          if (op_q != OpNop) begin
            flag_d = alu_flag;
          end
        end
      end

      StChain: begin
        res_d   = alu_result;
        f_d     = chain_flag;
        flag_d  = chain_flag;
        state_d = StResp;
      end

      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      a_q     <= '0;
      b_q     <= '0;
      chain_q <= 1'b0;
      res_q   <= '0;
      f_q     <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      chain_q <= chain_d;
      res_q   <= res_d;
      f_q     <= f_d;
      flag_q  <= flag_d;
    end
  end

  // ALU drive: second pass adds/subtracts one from the first-pass result.
  always_comb begin
    alu_op   = OpNop;
    alu_reg1 = '0;
    alu_reg2 = '0;
    unique case (state_q)
      StIssue: begin
        alu_op   = op_q;
        alu_reg1 = a_q;
        alu_reg2 = b_q;
      end
      StChain: begin
        alu_op   = op_q;
        alu_reg1 = res_q;
        alu_reg2 = DATA_BUS_WIDTH'(1);
      end
      default: begin
        alu_op   = OpNop;
        alu_reg1 = '0;
        alu_reg2 = '0;
      end
    endcase
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_result = res_q;
  assign bus.rsp_flag   = f_q;

  // Response payload must hold while the consumer stalls.
  rsp_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_result) &&
                                           $stable(bus.rsp_flag)));

  ready_valid_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.req_ready && bus.rsp_valid));

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized requests
// against an arithmetic reference model. A simple combinational ALU lives in the bench.

module tb_alu_sequencer;
  import controlpack::*;

`ifdef ALU_CARRY_CHAIN_EN
  localparam bit ChainEn = 1'b1;
`else
  localparam bit ChainEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  alu_op_e    alu_op;
  logic [7:0] alu_reg1;
  logic [7:0] alu_reg2;
  logic [7:0] alu_result;
  alu_flag_t  alu_flag;
  alu_flag_t  flag_q;

  int         n_total;
  int         n_bad;
  int         cyc;
  alu_flag_t  fq_m;

  alu_sequencer_if #(.DATA_BUS_WIDTH(8)) bus ();

  alu_sequencer #(.DATA_BUS_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_reg1   (alu_reg1),
    .alu_reg2   (alu_reg2),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .flag_q     (flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU: 9-bit add/sub, bit 8 is carry/borrow.
  logic [8:0] alu_wide;
  logic       alu_z;
  always_comb begin
    alu_wide = '0;
    case (alu_op)
      OpAdd:   alu_wide = {1'b0, alu_reg1} + {1'b0, alu_reg2};
      OpSub:   alu_wide = {1'b0, alu_reg1} - {1'b0, alu_reg2};
      OpAnd:   alu_wide = {1'b0, alu_reg1 & alu_reg2};
      OpOr:    alu_wide = {1'b0, alu_reg1 | alu_reg2};
      OpXor:   alu_wide = {1'b0, alu_reg1 ^ alu_reg2};
      default: alu_wide = '0;
    endcase
  end
  assign alu_z      = (alu_op != OpNop) && (alu_wide[7:0] == 8'h00);
  assign alu_result = alu_wide[7:0];
  assign alu_flag   = {alu_wide[8], alu_z};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-operation arithmetic; lat is the edge after acceptance at which
  // rsp_valid is first sampled high.
  function automatic void model(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                                input logic wc, output logic [7:0] r, output alu_flag_t f,
                                output int lat);
    int v;
    int extra;
    logic c;
    extra = (ChainEn && wc && fq_m.alu_carry && (op == OpAdd || op == OpSub)) ? 1 : 0;
    c = 1'b0;
    case (op)
      OpAdd: begin
        v = int'(a) + int'(b) + extra;
        c = (v > 255);
      end
      OpSub: begin
        v = int'(a) - int'(b) - extra;
        c = (v < 0);
      end
      OpAnd:   v = int'(a & b);
      OpOr:    v = int'(a | b);
      OpXor:   v = int'(a ^ b);
      default: v = 0;
    endcase
    r = v[7:0];
    f.alu_carry = c;
    f.alu_zero  = (op != OpNop) && (r == 8'h00);
    lat = 2 + extra;
  endfunction

  // Starts and ends at a negedge with the DUT idle.
  task automatic do_txn(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                        input logic wc, input int hold, output logic [7:0] obs_res,
                        output alu_flag_t obs_flag, output int acc_cyc);
    logic [7:0] er;
    alu_flag_t  ef;
    alu_flag_t  efq;
    int         elat;
    int         k;
    model(op, a, b, wc, er, ef, elat);
    efq = (op != OpNop) ? ef : fq_m;

    bus.req_valid      = 1'b1;
    bus.req_op         = op;
    bus.req_operand_a  = a;
    bus.req_operand_b  = b;
    bus.req_with_carry = wc;
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.req_operand_a = 8'($urandom);
    bus.req_operand_b = 8'($urandom);
    @(negedge clk);
    acc_cyc = cyc;
    check_eq("issue_op", 32'(alu_op), 32'(op));
    check_eq("issue_reg1", 32'(alu_reg1), 32'(a));
    check_eq("issue_reg2", 32'(alu_reg2), 32'(b));

    k = 0;
    while (!bus.rsp_valid && k < 6) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check_eq("latency", 32'(k + 1), 32'(elat));
    check_eq("rsp_result", 32'(bus.rsp_result), 32'(er));
    check_eq("rsp_flag", 32'(bus.rsp_flag), 32'(ef));
    check_eq("flag_q_resp", 32'(flag_q), 32'(efq));
    check_eq("resp_alu_op", 32'(alu_op), 32'(OpNop));
    check_eq("resp_alu_reg1", 32'(alu_reg1), 32'd0);
    obs_res  = bus.rsp_result;
    obs_flag = bus.rsp_flag;
    fq_m     = efq;

    for (int i = 0; i < hold; i++) begin
      bus.req_valid     = 1'b1;
      bus.req_op        = alu_op_e'($urandom_range(1, 5));
      bus.req_operand_a = 8'($urandom);
      bus.req_operand_b = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("hold_result", 32'(bus.rsp_result), 32'(er));
      check_eq("hold_flag", 32'(bus.rsp_flag), 32'(ef));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("post_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("post_flag_q", 32'(flag_q), 32'(fq_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    alu_flag_t  f;
    int         acc1;
    int         acc2;

    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    fq_m    = '0;
    rst_n   = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_op         = OpNop;
    bus.req_operand_a  = 8'h00;
    bus.req_operand_b  = 8'h00;
    bus.req_with_carry = 1'b0;
    bus.rsp_ready      = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check_eq("rst_rsp_flag", 32'(bus.rsp_flag), 32'd0);
    check_eq("rst_flag_q", 32'(flag_q), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'(OpNop));
    check_eq("rst_alu_regs", 32'({alu_reg1, alu_reg2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with carry out.
    do_txn(OpAdd, 8'hF0, 8'h20, 1'b0, 0, r, f, acc1);
    check_eq("t2_result", 32'(r), 32'h10);
    check_eq("t2_flag", 32'(f), 32'b10);
    check_eq("t2_flag_q", 32'(flag_q), 32'b10);

    // NOP keeps the flag register.
    do_txn(OpNop, 8'h55, 8'hAA, 1'b0, 0, r, f, acc1);
    check_eq("t6_result", 32'(r), 32'h00);
    check_eq("t6_flag", 32'(f), 32'b00);
    check_eq("t6_flag_q", 32'(flag_q), 32'b10);

    // ADC with carry set going in.
    do_txn(OpAdd, 8'hFF, 8'h00, 1'b1, 0, r, f, acc1);
    check_eq("t5_result", 32'(r), ChainEn ? 32'h00 : 32'hFF);
    check_eq("t5_flag", 32'(f), ChainEn ? 32'b11 : 32'b00);

    // SUB to zero.
    do_txn(OpSub, 8'h05, 8'h05, 1'b0, 0, r, f, acc1);
    check_eq("t3_result", 32'(r), 32'h00);
    check_eq("t3_flag_q", 32'(flag_q), 32'b01);

    // AND with three stalled response cycles.
    do_txn(OpAnd, 8'h3C, 8'h0F, 1'b0, 3, r, f, acc1);
    check_eq("t4_result", 32'(r), 32'h0C);

    // Back-to-back with response accepted at once: three-cycle interval.
    do_txn(OpOr, 8'h12, 8'h40, 1'b0, 0, r, f, acc1);
    do_txn(OpXor, 8'hFF, 8'h0F, 1'b0, 0, r, f, acc2);
    check_eq("issue_interval", 32'(acc2 - acc1), 32'd3);

    // Make flag_q non-zero, then reset while in ISSUE.
    do_txn(OpAdd, 8'h80, 8'h80, 1'b0, 0, r, f, acc1);
    bus.req_valid     = 1'b1;
    bus.req_op        = OpAdd;
    bus.req_operand_a = 8'h12;
    bus.req_operand_b = 8'h34;
    @(posedge clk);
    #2;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check_eq("t1_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("t1_alu_op", 32'(alu_op), 32'(OpNop));
    check_eq("t1_flag_q", 32'(flag_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fq_m  = '0;
    repeat (2) @(negedge clk);
    check_eq("t1_no_rsp", 32'(bus.rsp_valid), 32'd0);

    for (int n = 0; n < 60; n++) begin
      do_txn(alu_op_e'($urandom_range(0, 5)), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), r, f, acc1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
